// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, reset vector, base opcodes,
// the instruction-queue entry layout and the fetch FSM states.
package riscv_pkg;

    localparam int              XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order queue with synchronous flush and occupancy output.
// Flush takes priority over a same-cycle push or pop.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push writes into, so push-on-full is fine then.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC owner, credit-limited imem requester,
// in-order instruction queue and redirect flush. FETCH_PERF_EN adds perf counters.
module fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   occupancy;
    logic [SW-1:0]   credit_used;
    logic [XLEN-1:0] redirect_aligned;
    logic            req_fire;
    logic            rsp_keep;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    logic            unused_redirect_lsbs;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Every fetch holds a credit from request until it leaves the queue or is dropped.
    assign credit_used    = SW'(outstanding_q) + SW'(occupancy) + SW'(drop_cnt_q);
    assign imem_req_valid = (state_q == ST_RUN) && (credit_used < SW'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_cnt_q == '0);
    assign q_push         = rsp_keep && !redirect_valid;
    assign q_pop          = inst_valid && inst_ready;

    assign push_entry.pc   = rsp_pc_q;
    assign push_entry.inst = imem_rsp_data;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (q_push),
        .wdata (push_entry),
        .pop   (q_pop),
        .rdata (head_entry),
        .empty (q_empty),
        .count (occupancy)
    );

    assign inst_valid = !q_empty;
    assign inst_out   = inst_valid ? head_entry.inst : '0;
    assign inst_pc    = inst_valid ? head_entry.pc : '0;
    assign opcode     = inst_out[6:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            default: state_d = state_q;
        endcase

        if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        if (redirect_valid) begin
            // Everything in flight, including a request accepted right now, turns stale.
            pc_d          = redirect_aligned;
            rsp_pc_d      = redirect_aligned;
            drop_cnt_d    = drop_cnt_q + outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
            outstanding_d = '0;
        end else begin
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_keep);
            if (imem_rsp_valid && !rsp_keep) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (q_pop) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=4): reset, streaming, back-pressure,
// redirect flush, unaligned redirect and asynchronous reset mid-stream.
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          hs_cnt = 0;
    int          acc_cnt = 0;
    logic        rsp_hold = 1'b0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] mem_q[$];

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .opcode         (opcode)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction word returned by the memory model for a given address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[26:2], a[8:2]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: at most one response per cycle, strictly after acceptance.
    task automatic mem_drive();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!rsp_hold && mem_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_q.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_q.push_back(imem_req_addr);
            acc_cnt++;
        end
    endtask

    task automatic cycle();
        mem_drive();
        if (inst_valid && inst_ready) begin
            chk("hs_inst_pc", inst_pc, exp_pc);
            chk("hs_inst_out", inst_out, word_of(exp_pc));
            chk("hs_opcode", opcode, exp_pc[8:2]);
            $display("fetch pc=%h inst=%h opcode=%b", inst_pc, inst_out, opcode);
            exp_pc = exp_pc + 32'd4;
            hs_cnt++;
        end
        if (redirect_valid) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rsp_hold       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_q.delete();
        exp_pc = RST_PC;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_inst(input string tag, input logic [31:0] want_pc);
        for (int k = 0; k < 12 && !inst_valid; k++) begin
            cycle();
        end
        chk({tag, "_valid"}, inst_valid, 1'b1);
        chk({tag, "_pc"}, inst_pc, want_pc);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_opcode", opcode, 7'h0);
        rst_n = 1'b1;
        chk("boot_idle", imem_req_valid, 1'b0);
        cycle();
        chk("boot_req_valid", imem_req_valid, 1'b1);
        chk("boot_req_addr", imem_req_addr, 32'h8000_0000);

        // Streaming
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stream_req_valid", imem_req_valid, 1'b1);
            chk("stream_req_addr", imem_req_addr, RST_PC + 32'(4 * i));
            cycle();
        end
        hs_cnt = 0;
        repeat (8) cycle();
        chk("stream_throughput", hs_cnt, 8);

        // Back-pressure
        do_reset();
        cycle();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        acc_cnt        = 0;
        repeat (8) cycle();
        chk("bp_req_count", acc_cnt, DEPTH);
        chk("bp_req_valid", imem_req_valid, 1'b0);
        chk("bp_head_pc", inst_pc, 32'h8000_0000);
        inst_ready = 1'b1;
        cycle();
        chk("bp_resume_valid", imem_req_valid, 1'b1);
        chk("bp_resume_addr", imem_req_addr, 32'h8000_0010);
        repeat (6) cycle();

        // Redirect flush with two outstanding and one queued
        do_reset();
        cycle();
        imem_req_ready = 1'b1;
        cycle();
        cycle();
        rsp_hold = 1'b1;
        cycle();
        chk("flush_pre_queued", inst_valid, 1'b1);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        cycle();
        redirect_valid = 1'b0;
        chk("flush_empty", inst_valid, 1'b0);
        chk("flush_req_addr", imem_req_addr, 32'h8000_0100);
        imem_req_ready = 1'b1;
        rsp_hold       = 1'b0;
        inst_ready     = 1'b1;
        wait_inst("flush_first", 32'h8000_0100);
        repeat (4) cycle();
`ifdef FETCH_PERF_EN
        chk("perf_flush", perf_flush_cnt, 32'd1);
`endif

        // Unaligned redirect over an unaccepted request
        do_reset();
        cycle();
        chk("unal_pre_addr", imem_req_addr, 32'h8000_0000);
        cycle();
        chk("unal_hold_valid", imem_req_valid, 1'b1);
        chk("unal_hold_addr", imem_req_addr, 32'h8000_0000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0203;
        cycle();
        redirect_valid = 1'b0;
        chk("unal_req_valid", imem_req_valid, 1'b1);
        chk("unal_req_addr", imem_req_addr, 32'h8000_0200);
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        wait_inst("unal_first", 32'h8000_0200);
        repeat (4) cycle();

        // Asynchronous reset mid-stream with data queued
        inst_ready = 1'b0;
        repeat (4) cycle();
        chk("arst_pre_valid", inst_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", imem_req_valid, 1'b0);
        chk("arst_inst_valid", inst_valid, 1'b0);
        chk("arst_inst_out", inst_out, 32'h0);
        chk("arst_inst_pc", inst_pc, 32'h0);
        chk("arst_req_addr", imem_req_addr, RST_PC);
        mem_q.delete();
        imem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        exp_pc = RST_PC;
        inst_ready = 1'b1;
        chk("arst_boot_idle", imem_req_valid, 1'b0);
        cycle();
        chk("arst_restart_valid", imem_req_valid, 1'b1);
        chk("arst_restart_addr", imem_req_addr, RST_PC);
        wait_inst("arst_first", RST_PC);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. Produces the instruction word (and its opcode field) that the decode controller consumes, and consumes the decode/execute redirect (branch/jal/jalr target).
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel.
- Buffers returned words in a small in-order queue and presents them to decode with a valid/ready handshake.
- Discards stale responses after a redirect.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- DEPTH, 2, instruction queue entries; also the maximum outstanding-plus-buffered fetches (power of 2, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; responses return in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  XLEN  redirect target.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode consumes the head.
- inst_out  out  32  instruction word at the head.
- inst_pc  out  XLEN  PC of inst_out.
- opcode  out  7  inst_out[6:0], fed to the controller.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state=BOOT. All outputs 0 except imem_req_addr=RESET_PC.
- States:
  - BOOT: one cycle after reset release, no request, then RUN.
  - RUN: normal fetching.
- Credit:
  - imem_req_valid = (state==RUN) && (outstanding + occupancy + drop_cnt < DEPTH).
  - imem_rsp_valid is never back-pressured; the credit rule guarantees queue space.
- Request accepted (valid&&ready): outstanding+1; the request's PC is pushed into the in-flight PC FIFO; pc += 4.
- Response:
  - If drop_cnt>0: discard and decrement drop_cnt.
  - Otherwise: push {data, pc} into the queue and decrement outstanding.
- Decode handshake: inst_valid = !empty. Pop on inst_valid&&inst_ready. inst_out, inst_pc and opcode come from registered queue entries (no comb path from imem).
- Redirect (redirect_valid=1):
  - The pop in the same cycle completes first, then the queue is flushed.
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt <= drop_cnt + outstanding + (req accepted this cycle) - (rsp arrived this cycle).
  - outstanding <= 0.
  - A same-cycle response that would have been enqueued is dropped.
  - An unaccepted pending request changes its address to the new pc; this is the single permitted exception to address stability while valid is held.
- Otherwise, imem_req_addr is stable while imem_req_valid && !imem_req_ready.
- Simultaneous push and pop on a full queue is legal. pc wraps modulo 2^XLEN.
- Back-to-back redirects: the last one wins; drop_cnt accumulates.
- Reset mid-operation: everything clears immediately; in-flight responses after reset release must not arrive (memory is reset together).

Optional Feature:
- FETCH_PERF_EN defined adds:
  - perf_fetch_cnt out 32: count of inst handshakes.
  - perf_flush_cnt out 32: count of redirect cycles.
  - Both reset to 0 and wrap.
- Undefined: neither port exists; no extra logic.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and RESET_PC constants.
  - Opcode constants OPC_OP=7'b0110011, OPC_OP_IMM=7'b0010011, OPC_LOAD=7'b0000011, OPC_STORE=7'b0100011, OPC_BRANCH=7'b1100011, OPC_JALR=7'b1100111, OPC_JAL=7'b1101111, OPC_LUI=7'b0110111.
  - fetch_entry_t packed struct {pc, inst}.
- One sub-module, fetch_fifo: parameterised DEPTH, synchronous flush, occupancy output; instantiated for the instruction queue.

Test Plan:
- Reset: hold rst_n=0 -> imem_req_valid=0, inst_valid=0. Release -> one idle cycle, then imem_req_addr=32'h8000_0000.
- Streaming: req_ready=1, 1-cycle rsp latency, inst_ready=1, DEPTH=4 -> addresses 0x8000_0000/04/08/0C consecutive. inst_pc matches each word; steady-state 1 instruction/cycle; opcode equals inst_out[6:0].
- Back-pressure: inst_ready=0 -> exactly DEPTH requests issued, then imem_req_valid=0. inst_ready=1 resumes at the next sequential pc.
- Redirect flush: 2 outstanding and 1 queued, redirect_pc=0x8000_0100 -> queue empties. Both stale responses are discarded; next inst_pc=0x8000_0100.
- Unaligned redirect 0x8000_0203 together with an unaccepted request -> imem_req_addr becomes 0x8000_0200 on the following cycle.
- Async reset asserted mid-stream with data queued -> outputs clear within the same cycle. After release, fetch restarts at RESET_PC.
